// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU with registered result and flags.
// Opcodes: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL, 9-15 reserved.
// Optional feature macro: SEQ_ALU_MUL_EN compiles in the WIDTH-cycle shift-add
// multiplier and its BUSY state. Without it opcode 8 is treated as reserved.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_overflow;
  logic             r_zero;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_is_mul   = (operation == OP_MUL);
  assign w_mul_last = (r_state == BUSY) && (r_cnt == CW'(WIDTH - 1));
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_last = 1'b0;
`endif

  // r_in_ready mirrors IDLE, so this is a handshake only while idle
  assign w_accept  = in_valid & r_in_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  // Direct signed compare stays correct when a - b overflows
  assign w_slt  = ($signed(a) < $signed(b));

  // Single-cycle ALU result and overflow from the live operands (captured at accept)
  always_comb begin
    w_res = {WIDTH{1'b0}};
    w_ovf = 1'b0;
    case (operation)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  w_res = a ^ b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_AND:  w_res = a & b;
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      OP_OR:   w_res = a | b;
      default: begin
        w_res = {WIDTH{1'b0}};
        w_ovf = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, retire from DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_is_mul ? BUSY : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (w_mul_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus registered handshake flags decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Result/flag registers: load on single-cycle accept or on the last multiply step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out      <= {WIDTH{1'b0}};
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out      <= w_res;
      r_overflow <= w_ovf;
      r_zero     <= (w_res == {WIDTH{1'b0}});
`ifdef SEQ_ALU_MUL_EN
    end else if (w_mul_last) begin
      r_out      <= w_acc_nxt[WIDTH-1:0];
      r_overflow <= |w_acc_nxt[2*WIDTH-1:WIDTH];
      r_zero     <= (w_acc_nxt[WIDTH-1:0] == {WIDTH{1'b0}});
`endif
    end else begin
      r_out      <= r_out;
      r_overflow <= r_overflow;
      r_zero     <= r_zero;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // Shift-add multiplier: one multiplier bit per BUSY cycle, WIDTH cycles total
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (r_state == BUSY) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_nxt;
      r_cnt    <= r_cnt + CW'(1);
    end else begin
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_acc    <= r_acc;
      r_cnt    <= r_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed + random self-checking bench for seq_alu (WIDTH 32 and 8).
// Honours SEQ_ALU_MUL_EN for multiply expectations.
module tb_seq_alu;

`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit DUT signals
  logic        reset, in_valid, in_ready, out_valid, out_ready, overflow, zero;
  logic [3:0]  operation;
  logic [31:0] a, b, out;

  // 8-bit DUT signals
  logic        reset8, in_valid8, in_ready8, out_valid8, out_ready8, overflow8, zero8;
  logic [3:0]  operation8;
  logic [7:0]  a8, b8, out8;

  seq_alu #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .overflow(overflow), .zero(zero)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
    .operation(operation8), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out(out8), .overflow(overflow8), .zero(zero8)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: overflow derived from exact 64-bit arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic o);
    longint      s;
    logic [63:0] p;
    r = 32'd0;
    o = 1'b0;
    case (op)
      4'd0: begin
        s = longint'($signed(x)) + longint'($signed(y));
        r = s[31:0];
        o = (s != longint'($signed(r)));
      end
      4'd1: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r = s[31:0];
        o = (s != longint'($signed(r)));
      end
      4'd2: r = x ^ y;
      4'd3: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4: r = x & y;
      4'd5: r = ~(x & y);
      4'd6: r = ~(x | y);
      4'd7: r = x | y;
      4'd8: begin
        p = 64'(x) * 64'(y);
        if (MUL_EN) begin
          r = p[31:0];
          o = |p[63:32];
        end
      end
      default: begin
        r = 32'd0;
        o = 1'b0;
      end
    endcase
  endfunction

  // Push expectation, present the op for one accept edge, then scramble inputs
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    model(op, x, y, e.res, e.ovf);
    e.zf  = (e.res == 32'd0);
    e.lat = (op == 4'd8 && MUL_EN) ? 33 : 1;
    sb.push_back(e);
    @(negedge clk);
    chk("in_ready_before_send", in_ready, 1'b1);
    operation = op;
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operation = 4'($urandom_range(0, 15));
    a         = $urandom;
    b         = $urandom;
  endtask

  // Wait (bounded) for out_valid, measure latency and compare with scoreboard head
  task automatic get_result(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_out"}, out, e.res);
      chk({tag, "_ovf"}, overflow, e.ovf);
      chk({tag, "_zero"}, zero, e.zf);
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_in_ready_low"}, in_ready, 1'b0);
    end
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_retired_valid"}, out_valid, 1'b0);
    chk({tag, "_retired_ready"}, in_ready, 1'b1);
  endtask

  task automatic op_full(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    send(op, x, y);
    get_result(tag);
    retire(tag);
  endtask

  // Absolute time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence followed by a short random sweep
  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; operation = 4'd0; a = 32'd0; b = 32'd0;
    reset8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0; operation8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out", out, 32'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_zero", zero, 1'b0);
    reset = 1'b0;
    reset8 = 1'b0;

    op_full("add_2_1", 4'd0, 32'd2, 32'd1);
    op_full("add_max_pos", 4'd0, 32'h7FFF_FFFF, 32'd1);
    op_full("sub_min_neg", 4'd1, 32'h8000_0000, 32'd1);
    op_full("sub_5_5", 4'd1, 32'd5, 32'd5);
    op_full("slt_min_1", 4'd3, 32'h8000_0000, 32'd1);
    op_full("slt_1_m1", 4'd3, 32'd1, 32'hFFFF_FFFF);
    op_full("xor", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    op_full("and", 4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF);
    op_full("nand", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_full("nor", 4'd6, 32'h1234_0000, 32'h0000_5678);
    op_full("or", 4'd7, 32'h1234_0000, 32'h0000_5678);
    op_full("rsvd_9", 4'd9, 32'd7, 32'd9);
    op_full("rsvd_15", 4'd15, 32'hFFFF_FFFF, 32'd1);
    op_full("mul_6_7", 4'd8, 32'd6, 32'd7);
    op_full("mul_ovf", 4'd8, 32'h0001_0000, 32'h0001_0000);

    // Backpressure: result held, new request ignored while DONE
    send(4'd0, 32'd10, 32'd13);
    get_result("bp_add");
    operation = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_out", out, 32'd23);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_retire_valid", out_valid, 1'b0);
    chk("bp_retire_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_no_bypass_accept", out_valid, 1'b0);

    // in_valid coincident with reset must not be accepted
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; operation = 4'd0; a = 32'd2; b = 32'd1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_coinc_valid", out_valid, 1'b0);
    chk("rst_coinc_ready", in_ready, 1'b1);

    // Reset with a result in flight: mid-multiply if present, otherwise held in DONE
`ifdef SEQ_ALU_MUL_EN
    send(4'd8, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    chk("busy_valid_low", out_valid, 1'b0);
    chk("busy_ready_low", in_ready, 1'b0);
`else
    send(4'd0, 32'd4, 32'd4);
    repeat (3) @(negedge clk);
    chk("done_held_valid", out_valid, 1'b1);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    chk("rst_mid_out", out, 32'd0);
    op_full("add_after_rst", 4'd0, 32'd2, 32'd1);

    // Random sweep against the model
    for (int i = 0; i < 12; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? ra : $urandom;
      op_full("rand", rop, ra, rb);
    end

    // WIDTH=8: reset mid-op, then signed-overflow boundary
`ifdef SEQ_ALU_MUL_EN
    @(negedge clk);
    in_valid8 = 1'b1; operation8 = 4'd8; a8 = 8'd3; b8 = 8'd5;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("w8_busy_valid", out_valid8, 1'b0);
`endif
    @(negedge clk);
    reset8 = 1'b1;
    @(posedge clk);
    #1;
    reset8 = 1'b0;
    chk("w8_rst_valid", out_valid8, 1'b0);
    chk("w8_rst_ready", in_ready8, 1'b1);
    chk("w8_rst_out", out8, 8'd0);
    @(negedge clk);
    in_valid8 = 1'b1; operation8 = 4'd0; a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; a8 = 8'h00;
    @(negedge clk);
    chk("w8_add_valid", out_valid8, 1'b1);
    chk("w8_add_out", out8, 8'h80);
    chk("w8_add_ovf", overflow8, 1'b1);
    chk("w8_add_zero", zero8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit, operand/opcode presented.
REQ-005 SHALL have port in_ready, output, 1 bit, block can accept an operation.
REQ-006 SHALL have port operation, input, 4 bits: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL, 9-15 reserved.
REQ-007 SHALL have ports a and b, input, WIDTH bits each, operands (two's complement where signed).
REQ-008 SHALL have port out_valid, output, 1 bit, result held and valid.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-010 SHALL have port out, output, WIDTH bits, registered result.
REQ-011 SHALL have port overflow, output, 1 bit, registered overflow flag.
REQ-012 SHALL have port zero, output, 1 bit, registered flag, 1 when out == 0.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept an operation on a rising edge where in_valid & in_ready; a, b, operation captured at that edge; later input changes are ignored.
REQ-015 Ops 0-7 and reserved codes SHALL go IDLE -> DONE at the accept edge; out_valid high in the following cycle (1-cycle latency).
REQ-016 MUL SHALL go IDLE -> BUSY, run unsigned shift-add for exactly WIDTH cycles, then -> DONE; out_valid high WIDTH+1 cycles after accept.
REQ-017 In DONE, out/overflow/zero SHALL hold stable until an edge with out_ready = 1, then -> IDLE; out_valid low in IDLE and BUSY.
REQ-018 No new operation SHALL be accepted in the edge that retires a result (no bypass); next accept earliest one cycle later.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = signed overflow (operand signs equal-after-negation and result sign differs).
REQ-020 SLT SHALL produce 1 if a < b signed else 0, correct even when a - b overflows; overflow = 0.
REQ-021 XOR/AND/NAND/NOR/OR SHALL be bitwise; overflow = 0.
REQ-022 MUL SHALL produce low WIDTH bits of unsigned a*b; overflow = 1 iff upper WIDTH bits nonzero.
REQ-023 Reserved opcodes SHALL produce out = 0, overflow = 0, zero = 1, 1-cycle latency.
REQ-024 zero SHALL be computed from the registered result for every opcode.

Reset
REQ-025 reset SHALL force state IDLE, out = 0, overflow = 0, zero = 0, out_valid = 0, in_ready = 1 at the next rising edge.
REQ-026 reset SHALL take priority over all activity, including mid-MUL and DONE with out_ready low; the in-flight result is discarded.
REQ-027 An in_valid coincident with reset SHALL NOT be accepted.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN defined SHALL compile in MUL and the BUSY state per REQ-016/REQ-022.
REQ-029 Without SEQ_ALU_MUL_EN, opcode 8 SHALL behave as reserved (REQ-023), BUSY SHALL be unreachable, and all latencies SHALL be 1 cycle.

Verification (WIDTH = 32 unless noted)
REQ-030 ADD a=2, b=1 -> out=3, overflow=0, zero=0, out_valid one cycle after accept.
REQ-031 ADD 0x7FFFFFFF + 1 -> out=0x80000000, overflow=1; SUB 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1; SUB 5-5 -> 0, zero=1.
REQ-032 SLT a=0x80000000, b=1 -> out=1, overflow=0; SLT a=1, b=0xFFFFFFFF -> out=0.
REQ-033 With SEQ_ALU_MUL_EN: MUL 6*7 -> out=42, overflow=0, out_valid exactly 33 cycles after accept; MUL 0x10000*0x10000 -> out=0, overflow=1, zero=1; without macro MUL 6*7 -> out=0 after 1 cycle.
REQ-034 Backpressure: out_ready held 0 for 5 cycles after ADD 10+13 -> out=23 stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset asserted mid-MUL (cycle 10 of BUSY) -> next edge out_valid=0, in_ready=1, out=0; following ADD 2+1 returns 3 normally; repeat with WIDTH=8: ADD 0x7F+1 -> 0x80, overflow=1.
